booth_seq_mult: RTL

Parametrised sequential Booth multiplier, the next generation of the 8x8 radix-2 shift-add unit in the arithmetic library. It adds configurable operand width, a per-operation signed/unsigned mode, and an explicit start/busy/done handshake with a held result register. It also offers an optional radix-4 recoding path that roughly halves latency. It sits behind datapath controllers that issue one multiply at a time and wait for `done`.

---
 rtl/booth_seq_mult.sv | 129 ++++++++++++
 1 files changed

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier with start/busy/done handshake and held product.
// Define BOOTH_RADIX4_EN for radix-4 recoding (about half the cycles); default is radix-2.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prd
);

    localparam int QW = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int AW = WIDTH + 3;
    localparam int K  = WIDTH / 2 + 1;
`else
    localparam int AW = WIDTH + 2;
    localparam int K  = WIDTH + 1;
`endif
    localparam logic [5:0] LAST = 6'(K - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_a;
    logic [QW-1:0]      r_b;
    logic [QW-1:0]      r_q;
    logic               r_q1;
    logic [5:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_prd;

    logic [AW-1:0]      w_a_add;
    logic [AW-1:0]      w_a_next;
    logic [QW-1:0]      w_q_next;
    logic               w_q1_next;
    logic [2*WIDTH-1:0] w_prd;

`ifdef BOOTH_RADIX4_EN
    logic [AW-1:0]      w_b;
    logic [AW-1:0]      w_b2;

    assign w_b  = {r_b[QW-1], r_b};
    assign w_b2 = {w_b[AW-2:0], 1'b0};

    always_comb begin
        w_a_add = r_a;
        case ({r_q[1:0], r_q1})
            3'b001, 3'b010: w_a_add = r_a + w_b;
            3'b011:         w_a_add = r_a + w_b2;
            3'b100:         w_a_add = r_a - w_b2;
            3'b101, 3'b110: w_a_add = r_a - w_b;
            default:        w_a_add = r_a;
        endcase
        w_a_next  = {{2{w_a_add[AW-1]}}, w_a_add[AW-1:2]};
        w_q_next  = {w_a_add[1:0], r_q[QW-1:2]};
        w_q1_next = r_q[1];
        // W+2 bits shifted out of Q: the product is aligned at bit 0 of {A, Q}
        w_prd     = {w_a_next[WIDTH-3:0], w_q_next};
    end
`else
    always_comb begin
        w_a_add = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_a_add = r_a + r_b;
            2'b10:   w_a_add = r_a - r_b;
            default: w_a_add = r_a;
        endcase
        w_a_next  = {w_a_add[AW-1], w_a_add[AW-1:1]};
        w_q_next  = {w_a_add[0], r_q[QW-1:1]};
        w_q1_next = r_q[0];
        // Only W+1 of the W+2 Q bits are retired, so the product sits one bit up in {A, Q}
        w_prd     = {w_a_next[WIDTH-2:0], w_q_next[QW-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b     <= {{2{is_signed & mc[WIDTH-1]}}, mc};
                        r_q     <= {{2{is_signed & mp[WIDTH-1]}}, mp};
                        r_a     <= '0;
                        r_q1    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_q1  <= w_q1_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST) begin
                        r_prd   <= w_prd;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign prd  = r_prd;

endmodule
